// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and byte-enable/offset helpers for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP} lsu_state_e;

  // Lane offset with the low bits a misaligned access cannot use forced to 0.
  function automatic logic [1:0] off_of(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_B ? a : size == SZ_H ? {a[1], 1'b0} : 2'b00;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_B ? 4'b0001 << a : size == SZ_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-enable/data lane formatting and load lane extract with sign/zero extension.
import lsu_pkg::*;

module lsu_align (
  input  logic [1:0]  size_i,
  input  logic [1:0]  a_i,
  input  logic        uns_i,
  input  logic [31:0] din_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_o
);
  logic [31:0] sh;

  assign be_o    = be_of(size_i, a_i);
  assign wdata_o = size_i == SZ_B ? {4{din_i[7:0]}} : size_i == SZ_H ? {2{din_i[15:0]}} : din_i;
  assign sh      = rdata_i >> {off_of(size_i, a_i), 3'b000};
  assign ld_o    = size_i == SZ_B ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                   size_i == SZ_H ? {{16{~uns_i & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator FSM holding a byte-enabled word request until dm_ack.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with an addr_err pulse.
import lsu_pkg::*;

module lsu_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    size,
  input  logic          load_unsigned,
  input  logic [AW-1:0] ALU_result,
  input  logic [31:0]   din,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-3:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic          done,
  output logic [31:0]   dout,
  output logic          addr_err
);
  lsu_state_e  state_q, state_d;
  logic        we_q, uns_q, err_q, err_d;
  logic [1:0]  size_q, a_q;
  logic [3:0]  be_q;
  logic [AW-3:0] addr_q;
  logic [31:0] wdata_q, dout_q;
  logic        idle, accept, go, uns;
  logic [1:0]  sz, a;
  logic [3:0]  be;
  logic [31:0] wd, ld;

  assign idle   = state_q == LSU_IDLE;
  // Live inputs format the store at accept; the latched op drives the load extract later.
  assign sz     = idle ? size : size_q;
  assign a      = idle ? ALU_result[1:0] : a_q;
  assign uns    = idle ? load_unsigned : uns_q;
  assign accept = ex_valid & idle & (MemRead | MemWrite);

`ifdef LSU_ALIGN_CHECK_EN
  logic mis;
  assign mis   = (sz == SZ_H & a[0]) | (sz[1] & |a);
  assign go    = accept & ~mis;
  assign err_d = accept & mis;
`else
  assign go    = accept;
  assign err_d = 1'b0;
`endif

  lsu_align u_align (
    .size_i  (sz),
    .a_i     (a),
    .uns_i   (uns),
    .din_i   (din),
    .rdata_i (dm_rdata),
    .be_o    (be),
    .wdata_o (wd),
    .ld_o    (ld)
  );

  always_comb begin
    state_d = idle ? (go ? LSU_REQ : LSU_IDLE) :
              state_q == LSU_REQ ? (dm_ack ? LSU_RESP : LSU_REQ) : LSU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      a_q     <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dout_q  <= (state_q == LSU_REQ && dm_ack && !we_q) ? ld : 32'd0;
      if (go) begin
        we_q    <= MemWrite;
        uns_q   <= load_unsigned;
        size_q  <= size;
        a_q     <= ALU_result[1:0];
        be_q    <= be;
        addr_q  <= ALU_result[AW-1:2];
        wdata_q <= wd;
      end
    end
  end

  assign ex_ready = idle;
  assign dm_req   = state_q == LSU_REQ;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_be    = be_q;
  assign dm_wdata = wdata_q;
  assign done     = state_q == LSU_RESP;
  assign dout     = dout_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed-vector bench for lsu_ctrl with immediate-assertion checks.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready, MemRead, MemWrite, load_unsigned;
  logic [1:0]  size;
  logic [31:0] ALU_result, din, dm_rdata, dm_wdata, dout;
  logic        dm_req, dm_we, dm_ack, done, addr_err;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  int vectors = 0;
  int miscompares = 0;
  int req_cycles;

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .load_unsigned(load_unsigned),
    .ALU_result(ALU_result), .din(din), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .done(done), .dout(dout), .addr_err(addr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; MemWrite = w; MemRead = r; size = s; load_unsigned = u;
    ALU_result = a; din = d;
    tick;
    ex_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    dm_rdata = rd; dm_ack = 1'b1;
    tick;
    dm_ack = 1'b0; dm_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'b00;
    load_unsigned = 1'b0; ALU_result = 32'h0; din = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_we", {31'd0, dm_we}, 32'd0);
    chk("rst_be", {28'd0, dm_be}, 32'd0);
    chk("rst_addr", {2'b00, dm_addr}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);

    // sw 0x10 with two wait cycles
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_ready", {31'd0, ex_ready}, 32'd0);
    chk("sw_we", {31'd0, dm_we}, 32'd1);
    chk("sw_addr", {2'b00, dm_addr}, 32'h4);
    chk("sw_be", {28'd0, dm_be}, 32'hF);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (dm_req) req_cycles++;
      if (i < 2) tick;
    end
    ack(32'h0);
    chk("sw_req_cycles", req_cycles, 32'd3);
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_req_off", {31'd0, dm_req}, 32'd0);
    chk("sw_dout", dout, 32'd0);
    tick;
    chk("sw_done_pulse", {31'd0, done}, 32'd0);
    chk("sw_ready_back", {31'd0, ex_ready}, 32'd1);

    // sb a=3, MemRead also high: store wins
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h23, 32'h000000A5);
    chk("sb_we", {31'd0, dm_we}, 32'd1);
    chk("sb_addr", {2'b00, dm_addr}, 32'h8);
    chk("sb_be", {28'd0, dm_be}, 32'h8);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    ack(32'h0);
    chk("sb_done", {31'd0, done}, 32'd1);
    tick;

    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h0);
    chk("lb_we", {31'd0, dm_we}, 32'd0);
    chk("lb_be", {28'd0, dm_be}, 32'h4);
    ack(32'h0080FF00);
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_dout", dout, 32'hFFFFFF80);
    tick;
    chk("lb_dout_clr", dout, 32'd0);

    issue(1'b0, 1'b1, 2'b00, 1'b1, 32'h102, 32'h0);
    ack(32'h0080FF00);
    chk("lbu_dout", dout, 32'h00000080);
    tick;

    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0);
    chk("lh_be", {28'd0, dm_be}, 32'hC);
    ack(32'h80011234);
    chk("lh_dout", dout, 32'hFFFF8001);
    tick;

    issue(1'b0, 1'b1, 2'b01, 1'b1, 32'h202, 32'h0);
    ack(32'h80011234);
    chk("lhu_dout", dout, 32'h00008001);
    tick;

    // Idle strays: valid with no op, and an ack outside REQ
    ex_valid = 1'b1; dm_ack = 1'b1;
    tick;
    ex_valid = 1'b0; dm_ack = 1'b0;
    chk("noop_req", {31'd0, dm_req}, 32'd0);
    chk("noop_ready", {31'd0, ex_ready}, 32'd1);
    tick;
    chk("stray_ack_done", {31'd0, done}, 32'd0);

`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h0);
    chk("lw_mis_err", {31'd0, addr_err}, 32'd1);
    chk("lw_mis_req", {31'd0, dm_req}, 32'd0);
    chk("lw_mis_ready", {31'd0, ex_ready}, 32'd1);
    tick;
    chk("lw_mis_err_pulse", {31'd0, addr_err}, 32'd0);
    chk("lw_mis_done", {31'd0, done}, 32'd0);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h0);
    chk("lh_mis_err", {31'd0, addr_err}, 32'd1);
    chk("lh_mis_req", {31'd0, dm_req}, 32'd0);
    tick;
`else
    issue(1'b0, 1'b1, 2'b10, 1'b1, 32'h41, 32'h0);
    chk("lw_mis_req", {31'd0, dm_req}, 32'd1);
    chk("lw_mis_be", {28'd0, dm_be}, 32'hF);
    chk("lw_mis_addr", {2'b00, dm_addr}, 32'h10);
    chk("lw_mis_err", {31'd0, addr_err}, 32'd0);
    ack(32'h87654321);
    chk("lw_dout", dout, 32'h87654321);
    tick;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h0);
    chk("lh_mis_be", {28'd0, dm_be}, 32'hC);
    ack(32'h80011234);
    chk("lh_mis_dout", dout, 32'hFFFF8001);
    tick;
`endif

    // Reset while REQ, ack never given
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h80, 32'h0);
    chk("rq_req", {31'd0, dm_req}, 32'd1);
    chk("rq_be", {28'd0, dm_be}, 32'hF);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rq_rst_req", {31'd0, dm_req}, 32'd0);
    chk("rq_rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rq_rst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rq_no_done", {31'd0, done}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator sitting between the execute stage and the data memory. Accepts one load or store per handshake, formats byte/halfword/word accesses into word-addressed byte-enabled requests, holds the request until the memory acknowledges, then returns sign- or zero-extended load data. It stalls the pipeline while a transaction is outstanding.

## Interface
- `AW`, default 32: width of the byte address from the ALU.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: execute stage presents a memory operation.
- `ex_ready` out 1: the block can accept an operation; high only in IDLE.
- `MemRead` in 1: the operation is a load.
- `MemWrite` in 1: the operation is a store. If both `MemRead` and `MemWrite` are high, the store wins.
- `size` in 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `load_unsigned` in 1: zero-extend instead of sign-extend (lbu/lhu).
- `ALU_result` in AW: byte address.
- `din` in 32: store data, right-justified.
- `dm_req` out 1: request to memory; held until `dm_ack`.
- `dm_we` out 1: 1 for a store, 0 for a load.
- `dm_addr` out AW-2: word address, `ALU_result[AW-1:2]`.
- `dm_be` out 4: byte enables; lane k is bits [8k+7:8k], little-endian.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: memory completes the request this cycle; `dm_rdata` is valid.
- `dm_rdata` in 32: read word.
- `done` out 1: one-cycle pulse when a transaction completes.
- `dout` out 32: extended load data, valid with `done` for loads; 0 otherwise.
- `addr_err` out 1: one-cycle pulse for a misaligned access (see Configuration).

## Operation
- States:
  - IDLE: accept an operation when `ex_valid & ex_ready & (MemRead | MemWrite)`. `ex_valid` with neither flag set is ignored.
  - REQ: `dm_req` is high. `dm_addr`, `dm_we`, `dm_be` and `dm_wdata` are registered at accept and held stable.
  - RESP: `done` is high for one cycle. Return to IDLE.
- Transitions:
  - IDLE → REQ on accept.
  - REQ → RESP on `dm_ack`. Latch `dm_rdata` lane-extracted and extended into `dout`.
  - REQ stays in REQ while `dm_ack` is low. There is no timeout.
- Byte enables, with a = `ALU_result[1:0]`:
  - byte: `4'b0001 << a`.
  - halfword: `4'b0011 << a`, for a in {0, 2}.
  - word: `4'b1111`.
- Store data:
  - byte: `{4{din[7:0]}}`.
  - halfword: `{2{din[15:0]}}`.
  - word: `din`.
- Load extract:
  - byte: lane a.
  - halfword: lanes a+1:a.
  - Sign bit is the lane MSB unless `load_unsigned` is set.
  - Word loads ignore `load_unsigned`.
- `dm_ack` seen outside REQ is ignored.
- Reset values: state IDLE; `ex_ready`=1; `dm_req`=0, `dm_we`=0, `dm_be`=0, `dm_addr`=0, `dm_wdata`=0; `done`=0, `dout`=0, `addr_err`=0.
- Reset during REQ abandons the transaction. `dm_req` is low in the cycle after the reset edge, and no `done` pulse is produced.

## Timing
- Accept at edge 0 → `dm_req` high from edge 0.
- `dm_ack` sampled at edge N (N ≥ 1) → `done` and `dout` valid in the cycle after edge N.
- `ex_ready` returns high in the cycle after that.
- Zero-wait memory (ack in the first REQ cycle) gives 3 cycles from accept to the next accept.
- `ex_ready` is a registered state decode, with no combinational path from `ex_valid`.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A halfword with `a[0]`=1, or a word with a≠0, is rejected in IDLE.
  - `addr_err` pulses for one cycle after the accept edge.
  - No memory request is issued, `done` stays 0, and the state remains IDLE.
- Undefined:
  - The offending low address bits are forced to 0 (halfword uses `a[1]` only; word uses lane 0).
  - The access proceeds normally.
  - `addr_err` is tied to 0.

## Structure
- `lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`.
  - state enum `LSU_IDLE`, `LSU_REQ`, `LSU_RESP`.
  - function `be_of(size, a)`.
- Sub-module `lsu_align` (combinational):
  - store side: `be` and `wdata` formatting.
  - load side: lane extract and sign/zero extension.
- `lsu_ctrl` holds the FSM and registers.

## Test plan
- sw `ALU_result`=0x10, `din`=0xDEADBEEF, ack after 2 wait cycles → `dm_addr`=0x4, `dm_be`=1111, `dm_wdata`=0xDEADBEEF, `dm_req` high for 3 cycles, one `done` pulse.
- sb a=3, `din`=0x000000A5 → `dm_be`=1000, `dm_wdata`=0xA5A5A5A5.
- lb a=2, `dm_rdata`=0x0080FF00 → `dout`=0xFFFFFF80. Same with lbu → `dout`=0x00000080.
- lh a=2, `dm_rdata`=0x8001_1234 → `dout`=0xFFFF8001. Same with lhu → `dout`=0x00008001.
- lw a=1:
  - with `LSU_ALIGN_CHECK_EN`: `addr_err` pulse, no `dm_req`, `ex_ready` stays 1.
  - without it: request issued with `dm_be`=1111.
- Assert `rst` while in REQ, with ack never given → `dm_req`=0 and `ex_ready`=1 in the cycle after the reset edge, and `done` never pulses.
